// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_pkg
// Description : Shared definitions for the multiply unit: operation encodings,
//               FSM state encoding, iteration count and an operand helper.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_pkg;

  // Operation select encodings presented on the op port
  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MLA   = 2'b01,
    OP_UMULL = 2'b10,
    OP_SMULL = 2'b11
  } mul_op_e;

  // Multiply sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // One radix-2 shift-add iteration per multiplier bit
  localparam int unsigned MUL_ITERS    = 32;
  localparam int unsigned MUL_CNT_W    = 6;
  localparam logic [MUL_CNT_W-1:0] MUL_LAST_CNT = MUL_CNT_W'(MUL_ITERS - 1);

  // Magnitude of a two's-complement word. Worked in 33 bits so that
  // 0x80000000 yields +2^31 without overflow; the result always fits 32 bits.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    logic [32:0] ext;
    ext = {v[31], v};
    if (ext[32]) ext = ~ext + 33'd1;
    return ext[31:0];
  endfunction

endpackage : arm_pkg
`default_nettype wire

// File: rtl/mul_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mul_fsm
// Description : IDLE/CALC/DONE sequencer for the multiply unit. Owns the state
//               register, the iteration counter and the busy/done outputs, and
//               tells the datapath when to load, step and finalise.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_fsm
  import arm_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic i_start,
  input  logic i_flush,
  output logic o_busy,
  output logic o_done,
  output logic o_load,
  output logic o_step,
  output logic o_last
);

  mul_state_e             r_state;
  logic [MUL_CNT_W-1:0]   r_cnt;
  logic                   r_busy;
  logic                   r_done;

  // Flush suppresses every datapath action, so an aborted run changes nothing
  assign o_load = (r_state == ST_IDLE) && i_start && !i_flush;
  assign o_step = (r_state == ST_CALC) && !i_flush;
  assign o_last = o_step && (r_cnt == MUL_LAST_CNT);
  assign o_busy = r_busy;
  assign o_done = r_done;

  // State, counter and registered busy/done; flush beats start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_flush) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_CALC;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_CALC: begin
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == MUL_LAST_CNT) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule : mul_fsm
`default_nettype wire

// File: rtl/mul_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_unit
// Description : Iterative 32x32 multiplier (MUL, MLA, UMULL, SMULL). Radix-2
//               shift-add over 32 cycles, with op-specific finalisation and
//               N/Z flag generation on the last iteration edge.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_unit
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] acc,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic        flag_n,
  output logic        flag_z
);

  logic        w_load;
  logic        w_step;
  logic        w_last;
  mul_op_e     w_op;
  logic [31:0] w_mc;
  logic [31:0] w_mp;
  logic [32:0] w_sum;
  logic [63:0] w_acc_nxt;
  logic [63:0] w_signed;
  logic [31:0] w_fin_lo;
  logic [31:0] w_fin_hi;
  logic        w_fin_n;
  logic        w_fin_z;

  mul_op_e     r_op;
  logic [31:0] r_mc;
  logic [31:0] r_addend;
  logic        r_neg;
  logic [63:0] r_acc;
  logic [31:0] r_res_lo;
  logic [31:0] r_res_hi;
  logic        r_flag_n;
  logic        r_flag_z;

  mul_fsm u_fsm (
    .clk     (clk),
    .reset_n (reset_n),
    .i_start (start),
    .i_flush (flush),
    .o_busy  (busy),
    .o_done  (done),
    .o_load  (w_load),
    .o_step  (w_step),
    .o_last  (w_last)
  );

  // SMULL multiplies magnitudes; the sign is restored at finalisation
  assign w_op = mul_op_e'(op);
  assign w_mc = (w_op == OP_SMULL) ? mag32(a) : a;
  assign w_mp = (w_op == OP_SMULL) ? mag32(b) : b;

  // Upper half accumulates, lower half holds the remaining multiplier bits;
  // each step adds the multiplicand when the current LSB is set, then shifts.
  assign w_sum     = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_mc : 32'd0)};
  assign w_acc_nxt = {w_sum, r_acc[31:1]};
  assign w_signed  = r_neg ? (~w_acc_nxt + 64'd1) : w_acc_nxt;

  // Op-specific finalisation of the completed product, plus N/Z flags
  always_comb begin
    w_fin_lo = w_acc_nxt[31:0];
    w_fin_hi = 32'd0;
    w_fin_n  = 1'b0;
    case (r_op)
      OP_MUL:   w_fin_lo = w_acc_nxt[31:0];
      OP_MLA:   w_fin_lo = w_acc_nxt[31:0] + r_addend;
      OP_UMULL: {w_fin_hi, w_fin_lo} = w_acc_nxt;
      OP_SMULL: {w_fin_hi, w_fin_lo} = w_signed;
      default:  w_fin_lo = w_acc_nxt[31:0];
    endcase
    if ((r_op == OP_UMULL) || (r_op == OP_SMULL)) w_fin_n = w_fin_hi[31];
    else                                          w_fin_n = w_fin_lo[31];
    // hi is zero for 32-bit ops, so one compare covers both widths
    w_fin_z = ({w_fin_hi, w_fin_lo} == 64'd0);
  end

  // Operand capture, iteration and result registers (results only move on
  // the last iteration edge and otherwise hold)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op     <= OP_MUL;
      r_mc     <= 32'd0;
      r_addend <= 32'd0;
      r_neg    <= 1'b0;
      r_acc    <= 64'd0;
      r_res_lo <= 32'd0;
      r_res_hi <= 32'd0;
      r_flag_n <= 1'b0;
      r_flag_z <= 1'b0;
    end else if (w_load) begin
      r_op     <= w_op;
      r_mc     <= w_mc;
      r_addend <= acc;
      r_neg    <= (w_op == OP_SMULL) && (a[31] ^ b[31]);
      r_acc    <= {32'd0, w_mp};
    end else if (w_step) begin
      r_acc <= w_acc_nxt;
      if (w_last) begin
        r_res_lo <= w_fin_lo;
        r_res_hi <= w_fin_hi;
        r_flag_n <= w_fin_n;
        r_flag_z <= w_fin_z;
      end
    end
  end

  assign result_lo = r_res_lo;
  assign result_hi = r_res_hi;
  assign flag_n    = r_flag_n;
  assign flag_z    = r_flag_z;

endmodule : mul_unit
`default_nettype wire
